cp0_irq_ctrl: RTL and testbench

Parametrised coprocessor-0 for the pipelined MIPS core, and the successor to the single-line CP0.
- Supports IRQ_N external interrupt lines plus one internal timer-compare line, each with a per-line mask.
- Lines are arbitrated by fixed priority; EXL-based re-entry protection; timer/compare pair.
- Read port is used in ID, write/ERET in EXE; interrupt take is evaluated every cycle and drives a held jump request to IF.

---
 rtl/cp0_irq_ctrl.sv | 163 ++++++++++++++++
 tb/tb_cp0_irq_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_irq_ctrl.sv
// Coprocessor-0 interrupt controller: IRQ_N edge-triggered lines plus a timer-compare line,
// fixed-priority take with EXL protection and a held jump request. Define CP0_VECTOR_EN for vectored targets.
module cp0_irq_ctrl #(
  parameter int DATA_W    = 32,
  parameter int IRQ_N     = 4,
  parameter int VEC_SHIFT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        oper,
  input  logic [4:0]        addr_r,
  output logic [DATA_W-1:0] data_r,
  input  logic [4:0]        addr_w,
  input  logic [DATA_W-1:0] data_w,
  input  logic              ir_en,
  input  logic [IRQ_N-1:0]  ir_in,
  input  logic [DATA_W-1:0] ret_addr,
  output logic              jump_en,
  output logic [DATA_W-1:0] jump_addr,
  input  logic              jump_ack
);
  localparam int L = IRQ_N + 1;

  typedef enum logic [1:0] {OP_NONE = 2'd0, OP_MFC0 = 2'd1, OP_MTC0 = 2'd2, OP_ERET = 2'd3} oper_e;
  typedef enum logic [4:0] {
    R_SR = 5'd0, R_CAUSE = 5'd1, R_EPC = 5'd2, R_EHBR = 5'd3, R_TCR = 5'd4, R_TCMP = 5'd5
  } reg_e;

  if (DATA_W < 16 || IRQ_N < 1 || IRQ_N > 7 || VEC_SHIFT < 0 || VEC_SHIFT >= DATA_W) begin : g_bad_param
    $error("cp0_irq_ctrl: parameter out of range");
  end

  logic              ie_q, ie_d, exl_q, exl_d;
  logic [L-1:0]      mask_q, mask_d, pend_q, pend_d;
  logic [4:0]        code_q, code_d;
  logic [DATA_W-1:0] epc_q, epc_d, ehbr_q, ehbr_d, tcr_q, tcr_d, tcmp_q, tcmp_d;
  logic [IRQ_N-1:0]  ir_s_q, ir_prev_q;
  logic              jump_en_q, jump_en_d;
  logic [DATA_W-1:0] jump_addr_q, jump_addr_d;

  logic         wr, eret, take, found, tmatch;
  logic [L-1:0] req, first, set_ev;
  logic [4:0]   win;

  always_comb begin
    wr     = (oper == OP_MTC0);
    eret   = (oper == OP_ERET);
    tmatch = (tcmp_q != '0) && (tcr_q == tcmp_q);
    set_ev = {tmatch, ir_s_q & ~ir_prev_q};
    req    = pend_q & mask_q;
    found  = 1'b0;
    first  = '0;
    win    = '0;
    for (int unsigned k = 0; k < L; k++) begin
      if (req[k] && !found) begin
        found    = 1'b1;
        first[k] = 1'b1;
        win      = 5'(k);
      end
    end
    take = ir_en && ie_q && !exl_q && found && !eret;

    ie_d        = ie_q;
    exl_d       = exl_q;
    mask_d      = mask_q;
    code_d      = code_q;
    epc_d       = epc_q;
    ehbr_d      = ehbr_q;
    tcr_d       = tcr_q + DATA_W'(1);
    tcmp_d      = tcmp_q;
    jump_en_d   = jump_en_q && !jump_ack;
    jump_addr_d = jump_addr_q;
    // A new event on a line beats the clear of that same line by a take.
    pend_d      = (pend_q & ~(take ? first : '0)) | set_ev;

    if (wr) begin
      case (reg_e'(addr_w))
        R_SR: begin
          ie_d   = data_w[0];
          exl_d  = data_w[1];
          mask_d = data_w[8 +: L];
        end
        R_EPC:   epc_d  = data_w;
        R_EHBR:  ehbr_d = data_w;
        R_TCR:   tcr_d  = data_w;
        R_TCMP:  tcmp_d = data_w;
        default: ;
      endcase
    end

    // Hardware EPC/EXL updates are applied last so they override a same-cycle MTC0.
    if (take) begin
      epc_d     = ret_addr;
      exl_d     = 1'b1;
      code_d    = win;
      jump_en_d = 1'b1;
`ifdef CP0_VECTOR_EN
      jump_addr_d = ehbr_q + (DATA_W'(win) << VEC_SHIFT);
`else
      jump_addr_d = ehbr_q;
`endif
    end else if (eret) begin
      exl_d       = 1'b0;
      jump_en_d   = 1'b1;
      jump_addr_d = epc_q;
    end
  end

  always_comb begin
    data_r = '0;
    case (reg_e'(addr_r))
      R_SR: begin
        data_r[0]     = ie_q;
        data_r[1]     = exl_q;
        data_r[8 +: L] = mask_q;
      end
      R_CAUSE: begin
        data_r[6:2]    = code_q;
        data_r[8 +: L] = pend_q;
      end
      R_EPC:   data_r = epc_q;
      R_EHBR:  data_r = ehbr_q;
      R_TCR:   data_r = tcr_q;
      R_TCMP:  data_r = tcmp_q;
      default: data_r = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ie_q        <= 1'b0;
      exl_q       <= 1'b0;
      mask_q      <= '0;
      pend_q      <= '0;
      code_q      <= '0;
      epc_q       <= '0;
      ehbr_q      <= '0;
      tcr_q       <= '0;
      tcmp_q      <= '0;
      ir_s_q      <= '0;
      ir_prev_q   <= '0;
      jump_en_q   <= 1'b0;
      jump_addr_q <= '0;
    end else begin
      ie_q        <= ie_d;
      exl_q       <= exl_d;
      mask_q      <= mask_d;
      pend_q      <= pend_d;
      code_q      <= code_d;
      epc_q       <= epc_d;
      ehbr_q      <= ehbr_d;
      tcr_q       <= tcr_d;
      tcmp_q      <= tcmp_d;
      ir_s_q      <= ir_in;
      ir_prev_q   <= ir_s_q;
      jump_en_q   <= jump_en_d;
      jump_addr_q <= jump_addr_d;
    end
  end

  assign jump_en   = jump_en_q;
  assign jump_addr = jump_addr_q;
endmodule

// File: tb/tb_cp0_irq_ctrl.sv
// Bench for cp0_irq_ctrl: directed scenarios with literal expectations plus randomized traffic
// checked every cycle against a behavioural model of the register/interrupt rules.
module tb_cp0_irq_ctrl;
  localparam int DW = 32;
  localparam int NI = 4;
  localparam int VS = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    oper = '0;
  logic [4:0]    addr_r = '0, addr_w = '0;
  logic [DW-1:0] data_w = '0, ret_addr = '0;
  logic          ir_en = 1'b0, jump_ack = 1'b0;
  logic [NI-1:0] ir_in = '0;
  logic [DW-1:0] data_r, jump_addr;
  logic          jump_en;

  int checks = 0;
  int errors = 0;

  cp0_irq_ctrl #(.DATA_W(DW), .IRQ_N(NI), .VEC_SHIFT(VS)) dut (
    .clk(clk), .rst_n(rst_n), .oper(oper), .addr_r(addr_r), .data_r(data_r),
    .addr_w(addr_w), .data_w(data_w), .ir_en(ir_en), .ir_in(ir_in),
    .ret_addr(ret_addr), .jump_en(jump_en), .jump_addr(jump_addr), .jump_ack(jump_ack)
  );

  always #5 clk = ~clk;

  // Behavioural model: plain integers, updated once per rising edge from pre-edge values.
  bit          m_ie, m_exl, m_jen;
  int unsigned m_mask, m_pend, m_code;
  bit [31:0]   m_epc, m_ehbr, m_tcr, m_tcmp, m_jaddr;
  bit [NI-1:0] h1, h2;

  task automatic m_reset();
    m_ie = 0; m_exl = 0; m_jen = 0;
    m_mask = 0; m_pend = 0; m_code = 0;
    m_epc = 0; m_ehbr = 0; m_tcr = 0; m_tcmp = 0; m_jaddr = 0;
    h1 = '0; h2 = '0;
  endtask

  function automatic bit [31:0] mread(input logic [4:0] a);
    case (a)
      5'd0: return {30'd0, m_exl, m_ie} | (m_mask << 8);
      5'd1: return (m_pend << 8) | (m_code << 2);
      5'd2: return m_epc;
      5'd3: return m_ehbr;
      5'd4: return m_tcr;
      5'd5: return m_tcmp;
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    int unsigned newp, req, w;
    bit tk, er;
    bit [31:0] tgt, etgt;
    if (!rst_n) m_reset();
    else begin
      er = (oper == 2'd3);
      newp = 32'(h1 & ~h2);
      if (m_tcmp != 0 && m_tcr == m_tcmp) newp |= (1 << NI);
      req = m_pend & m_mask;
      tk = ir_en && m_ie && !m_exl && (req != 0) && !er;
      w = 0;
      while (w < 8 && ((req >> w) & 1) == 0) w++;
`ifdef CP0_VECTOR_EN
      tgt = m_ehbr + (w << VS);
`else
      tgt = m_ehbr;
`endif
      etgt = m_epc;
      m_tcr = m_tcr + 1;
      m_pend = (m_pend & ~(tk ? (1 << w) : 0)) | newp;
      if (oper == 2'd2) begin
        case (addr_w)
          5'd0: begin m_ie = data_w[0]; m_exl = data_w[1]; m_mask = (data_w >> 8) & 32'h1F; end
          5'd2: m_epc = data_w;
          5'd3: m_ehbr = data_w;
          5'd4: m_tcr = data_w;
          5'd5: m_tcmp = data_w;
          default: ;
        endcase
      end
      if (tk) begin
        m_epc = ret_addr; m_exl = 1; m_code = w; m_jen = 1; m_jaddr = tgt;
      end else if (er) begin
        m_exl = 0; m_jen = 1; m_jaddr = etgt;
      end else if (jump_ack) m_jen = 0;
      h2 = h1;
      h1 = ir_in;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("jump_en_vs_model", {31'd0, jump_en}, {31'd0, m_jen});
    chk("jump_addr_vs_model", jump_addr, m_jaddr);
    chk("data_r_vs_model", data_r, mread(addr_r));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic [1:0] o, input logic [4:0] aw, input logic [31:0] dw);
    oper = o; addr_w = aw; data_w = dw;
    step();
    oper = 2'd0;
  endtask

  task automatic rdchk(input string nm, input logic [4:0] a, input logic [31:0] exp);
    addr_r = a;
    #1;
    chk(nm, data_r, exp);
  endtask

  task automatic ack();
    jump_ack = 1'b1;
    step();
    jump_ack = 1'b0;
  endtask

  localparam logic [31:0] VEC2 =
`ifdef CP0_VECTOR_EN
    32'h120;
`else
    32'h100;
`endif
  localparam logic [31:0] VEC4 =
`ifdef CP0_VECTOR_EN
    32'h140;
`else
    32'h100;
`endif

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("reset_jump_en", {31'd0, jump_en}, 32'd0);
    chk("reset_jump_addr", jump_addr, 32'd0);
    rdchk("reset_sr", 5'd0, 32'd0);
    rdchk("reset_epc", 5'd2, 32'd0);

    // Single line take
    cyc(2'd2, 5'd0, 32'h301);
    cyc(2'd2, 5'd3, 32'h100);
    ret_addr = 32'h40; ir_en = 1'b1; ir_in = 4'b0010;
    step();
    ir_in = '0;
    step();
    chk("t1_no_jump_yet", {31'd0, jump_en}, 32'd0);
    rdchk("t1_pend", 5'd1, 32'h200);
    step();
    chk("t1_jump_en", {31'd0, jump_en}, 32'd1);
    chk("t1_jump_addr", jump_addr, 32'h100);
    rdchk("t1_epc", 5'd2, 32'h40);
    rdchk("t1_cause", 5'd1, 32'h4);
    rdchk("t1_sr", 5'd0, 32'h303);
    repeat (3) step();
    chk("t1_held", {31'd0, jump_en}, 32'd1);
    ack();
    chk("t1_acked", {31'd0, jump_en}, 32'd0);

    // Priority, then ERET followed by the remaining line
    cyc(2'd3, 5'd0, 32'd0);
    chk("t2_eret_addr", jump_addr, 32'h40);
    rdchk("t2_sr_after_eret", 5'd0, 32'h301);
    jump_ack = 1'b1;
    cyc(2'd2, 5'd0, 32'h1F01);
    jump_ack = 1'b0;
    ret_addr = 32'h80; ir_in = 4'b0101;
    step();
    ir_in = '0;
    step();
    step();
    chk("t2_take0", jump_addr, 32'h100);
    rdchk("t2_cause_pend2", 5'd1, 32'h400);
    ack();
    cyc(2'd3, 5'd0, 32'd0);
    chk("t2_eret_wins", jump_addr, 32'h80);
    ret_addr = 32'h90;
    step();
    chk("t2_take2_addr", jump_addr, VEC2);
    rdchk("t2_cause_code2", 5'd1, 32'h8);
    rdchk("t2_epc", 5'd2, 32'h90);

    // Pending held while ir_en is low
    ack();
    ret_addr = 32'hA0;
    cyc(2'd3, 5'd0, 32'd0);
    chk("t3_eret_addr", jump_addr, 32'h90);
    ack();
    ir_en = 1'b0; ir_in = 4'b1000;
    step();
    ir_in = '0;
    repeat (4) step();
    chk("t3_no_jump", {31'd0, jump_en}, 32'd0);
    rdchk("t3_pend3", 5'd1, 32'h808);
    ir_en = 1'b1;
    step();
    chk("t3_take", {31'd0, jump_en}, 32'd1);
    rdchk("t3_cause", 5'd1, 32'hC);

    // Timer compare
    ack();
    cyc(2'd3, 5'd0, 32'd0);
    ack();
    cyc(2'd2, 5'd0, 32'h1001);
    cyc(2'd2, 5'd5, 32'd10);
    cyc(2'd2, 5'd4, 32'd0);
    repeat (10) step();
    rdchk("t4_tcr10", 5'd4, 32'd10);
    chk("t4_no_jump", {31'd0, jump_en}, 32'd0);
    step();
    rdchk("t4_timer_pend", 5'd1, 32'h100C);
    step();
    chk("t4_take", {31'd0, jump_en}, 32'd1);
    chk("t4_addr", jump_addr, VEC4);
    rdchk("t4_cause", 5'd1, 32'h10);

    // Asynchronous reset while a jump is held
    #1 rst_n = 1'b0;
    #1;
    chk("t6_jump_en", {31'd0, jump_en}, 32'd0);
    chk("t6_jump_addr", jump_addr, 32'd0);
    rdchk("t6_sr", 5'd0, 32'd0);
    rdchk("t6_ehbr", 5'd3, 32'd0);
    #2 rst_n = 1'b1;
    step();

    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 99);
      oper = (r < 10) ? 2'd3 : (r < 35) ? 2'd2 : (r < 45) ? 2'd1 : 2'd0;
      addr_w = 5'($urandom_range(0, 7));
      if (addr_w == 5'd4 || addr_w == 5'd5) data_w = $urandom_range(0, 40);
      else if (addr_w == 5'd0) data_w = ($urandom & 32'hFFFF_FFFD) | 32'((r % 4) != 0);
      else data_w = $urandom;
      ir_en = ($urandom_range(0, 3) != 0);
      jump_ack = ($urandom_range(0, 2) == 0);
      addr_r = 5'($urandom_range(0, 7));
      ret_addr = $urandom;
      if ($urandom_range(0, 3) == 0) ir_in = NI'($urandom);
      step();
    end
    oper = 2'd0; jump_ack = 1'b0; ir_in = '0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
